// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
//   ld_size_e : load access size encoding (reserved 2'b11 behaves as a word)
//   wb_src_e  : which upstream source owns the write slot this cycle
//   STARVE_W  : width of the execute starvation counter
package wb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_e;

  typedef enum logic {
    SRC_EX = 1'b0,
    SRC_LD = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_ld_align.sv
// wb_ld_align: combinational lane select and sign/zero extension of load data.
// Ports:
//   rdata       in  XLEN  raw aligned memory word
//   addr_lo     in  2     byte offset of the load address
//   size        in  2     00 byte, 01 half, 10 word, 11 treated as word
//   ld_unsigned in  1     zero-extend instead of sign-extend
//   data        out XLEN  formatted load result
module wb_ld_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword lane uses only addr_lo[1]; bit 0 is ignored on purpose.
    if (addr_lo[1]) begin
      half_sel = rdata[31:16];
    end else begin
      half_sel = rdata[15:0];
    end
  end

  // Extend the selected lane to the full datapath width.
  always_comb begin
    data = rdata;
    case (size)
      LD_B:    data = {{(XLEN-8){byte_sel[7] & ~ld_unsigned}}, byte_sel};
      LD_H:    data = {{(XLEN-16){half_sel[15] & ~ld_unsigned}}, half_sel};
      LD_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage in front of the integer register file.
// Arbitrates execute results against load responses (loads favoured, with a
// starvation limit for execute), formats load data, registers a single write
// and bypasses that pending write onto the register-file read data.
// Build option: define WB_BYPASS_EN to enable the read bypass muxes; without
// it rsN_data passes rsN_rf_data straight through.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_valid/ex_ready/ex_rd/ex_wen/ex_data           execute result channel
//   ld_valid/ld_ready/ld_rd/ld_rdata/ld_addr_lo/
//   ld_size/ld_unsigned                              load response channel
//   rd_addr/rd_data/rd_wr_en      register-file write port (registered)
//   rs1_addr/rs2_addr, rs1_rf_data/rs2_rf_data       register-file reads
//   rs1_data/rs2_data             read data after bypass
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wen,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [1:0]      ld_addr_lo,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wr_en,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rf_data,
  input  logic [XLEN-1:0] rs2_rf_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic                rd_wr_en_q, rd_wr_en_d;

  logic            ex_gnt;
  logic            ld_gnt;
  wb_src_e         src;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] ld_fmt;
  logic            wr_want;

  wb_ld_align #(.XLEN(XLEN)) u_align (
    .rdata       (ld_rdata),
    .addr_lo     (ld_addr_lo),
    .size        (ld_size),
    .ld_unsigned (ld_unsigned),
    .data        (ld_fmt)
  );

  // Grant: load wins a tie unless execute has waited STARVE_MAX grants.
  always_comb begin
    ex_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst) begin
      ex_gnt = 1'b0;
      ld_gnt = 1'b0;
    end else if (ex_valid && ld_valid) begin
      if (starve_q == STARVE_MAX_C) begin
        ex_gnt = 1'b1;
      end else begin
        ld_gnt = 1'b1;
      end
    end else if (ex_valid) begin
      ex_gnt = 1'b1;
    end else if (ld_valid) begin
      ld_gnt = 1'b1;
    end else begin
      ex_gnt = 1'b0;
      ld_gnt = 1'b0;
    end
  end

  assign ex_ready = ex_gnt;
  assign ld_ready = ld_gnt;

  // Starvation counter: counts load grants that made a waiting execute wait.
  always_comb begin
    starve_d = {STARVE_W{1'b0}};
    if (ld_gnt && ex_valid) begin
      if (starve_q == STARVE_MAX_C) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end else begin
      starve_d = {STARVE_W{1'b0}};
    end
  end

  // Select the granted source and decide whether it really writes.
  always_comb begin
    src     = ld_gnt ? SRC_LD : SRC_EX;
    wb_addr = ex_rd;
    wb_data = ex_data;
    case (src)
      SRC_LD: begin
        wb_addr = ld_rd;
        wb_data = ld_fmt;
      end
      SRC_EX: begin
        wb_addr = ex_rd;
        wb_data = ex_data;
      end
      default: begin
        wb_addr = ex_rd;
        wb_data = ex_data;
      end
    endcase
    // x0 is hardwired; a suppressed execute result is still consumed.
    wr_want    = ld_gnt | (ex_gnt & ex_wen);
    rd_wr_en_d = wr_want & (wb_addr != 5'd0);
    if (ex_gnt || ld_gnt) begin
      rd_addr_d = wb_addr;
      rd_data_d = wb_data;
    end else begin
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
    end
  end

  // State and write-port registers; reset discards any pending write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= {STARVE_W{1'b0}};
      rd_addr_q  <= 5'd0;
      rd_data_q  <= {XLEN{1'b0}};
      rd_wr_en_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_wr_en_q <= rd_wr_en_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_wr_en = rd_wr_en_q;

`ifdef WB_BYPASS_EN
  // Forward the pending write: the register file still returns the old value.
  always_comb begin
    if (rd_wr_en_q && (rd_addr_q == rs1_addr) && (rs1_addr != 5'd0)) begin
      rs1_data = rd_data_q;
    end else begin
      rs1_data = rs1_rf_data;
    end
    if (rd_wr_en_q && (rd_addr_q == rs2_addr) && (rs2_addr != 5'd0)) begin
      rs2_data = rd_data_q;
    end else begin
      rs2_data = rs2_rf_data;
    end
  end
`else
  assign rs1_data = rs1_rf_data;
  assign rs2_data = rs2_rf_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed scoreboard bench for wb_stage.
module tb_wb_stage;

  localparam int SMAX = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_wen = 1'b0, ld_valid = 1'b0, ld_unsigned = 1'b0;
  logic        ex_ready, ld_ready, rd_wr_en;
  logic [4:0]  ex_rd = 5'd0, ld_rd = 5'd0, rs1_addr = 5'd0, rs2_addr = 5'd0, rd_addr;
  logic [1:0]  ld_addr_lo = 2'd0, ld_size = 2'd0;
  logic [31:0] ex_data = 32'd0, ld_rdata = 32'd0, rs1_rf_data = 32'd0, rs2_rf_data = 32'd0;
  logic [31:0] rd_data, rs1_data, rs2_data;

  wb_stage #(.XLEN(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_rdata(ld_rdata),
    .ld_addr_lo(ld_addr_lo), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wr_en(rd_wr_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rf_data(rs1_rf_data), .rs2_rf_data(rs2_rf_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          starve = 0;
  logic        pend_v = 1'b0;
  logic [4:0]  pend_a = 5'd0;
  logic [31:0] pend_d = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic un);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * lo)) & 32'h0000_00FF;
      if (!un && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * lo[1])) & 32'h0000_FFFF;
      if (!un && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] byp_model(input logic [4:0] a, input logic [31:0] rf);
    if (BYP && pend_v && pend_a == a && a != 5'd0) return pend_d;
    return rf;
  endfunction

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    if (rd_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got write r%0d=%h expected none at %0t", rd_addr, rd_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, rd_addr}, {27'd0, e.addr});
        chk("wr_data", rd_data, e.data);
      end
    end
  end

  // One clock cycle of stimulus; model grant, readies, bypass and the write.
  task automatic cycle(input logic exv, input logic [4:0] exrd, input logic exw, input logic [31:0] exd,
                       input logic ldv, input logic [4:0] ldrd, input logic [31:0] ldd,
                       input logic [1:0] lo, input logic [1:0] sz, input logic un,
                       input logic [4:0] r1, input logic [31:0] r1d,
                       input logic [4:0] r2, input logic [31:0] r2d,
                       output logic o_wr, output logic [31:0] o_data,
                       output logic [31:0] o_rs1, output logic o_ld_rdy);
    logic eg, lg, w;
    logic [4:0] a;
    logic [31:0] d;
    @(posedge clk);
    #1;
    ex_valid = exv; ex_rd = exrd; ex_wen = exw; ex_data = exd;
    ld_valid = ldv; ld_rd = ldrd; ld_rdata = ldd; ld_addr_lo = lo; ld_size = sz; ld_unsigned = un;
    rs1_addr = r1; rs1_rf_data = r1d; rs2_addr = r2; rs2_rf_data = r2d;
    #2;
    o_wr = rd_wr_en; o_data = rd_data; o_rs1 = rs1_data; o_ld_rdy = ld_ready;
    chk("wr_en", {31'd0, rd_wr_en}, {31'd0, pend_v});
    chk("rs1_data", rs1_data, byp_model(r1, r1d));
    chk("rs2_data", rs2_data, byp_model(r2, r2d));
    eg = 1'b0; lg = 1'b0;
    if (exv && ldv) begin
      if (starve == SMAX) eg = 1'b1; else lg = 1'b1;
    end else begin
      eg = exv; lg = ldv;
    end
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, eg});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, lg});
    a = lg ? ldrd : exrd;
    d = lg ? ld_model(ldd, lo, sz, un) : exd;
    w = (lg || (eg && exw)) && a != 5'd0;
    if (w) exp_q.push_back('{addr: a, data: d});
    pend_v = w; pend_a = a; pend_d = d;
    if (lg && exv) starve = (starve < SMAX) ? starve + 1 : starve;
    else starve = 0;
  endtask

  logic        o_wr, o_ldr;
  logic [31:0] o_data, o_rs1;
  logic [9:0]  pat;

  initial begin
    // Reset state
    #1;
    chk("rst_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    ex_valid = 1'b1; ld_valid = 1'b1;
    #1;
    chk("rst_readies", {30'd0, ex_ready, ld_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0;

    // Execute only, r5 <- 0x1234
    cycle(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("ex_write_en", {31'd0, o_wr}, 32'd1);
    chk("ex_write_data", o_data, 32'h0000_1234);
    chk("ex_write_addr", {27'd0, rd_addr}, 32'd5);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("ex_write_oneshot", {31'd0, o_wr}, 32'd0);

    // Load formatting directed cases
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 32'h80FF_7F01, 2'd3, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 32'h80FF_7F01, 2'd3, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("lb_signed", o_data, 32'hFFFF_FF80);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 32'h80FF_7F01, 2'd2, 2'd1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("lbu", o_data, 32'h0000_0080);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("lh_signed", o_data, 32'hFFFF_80FF);

    // Starvation: both valid for 10 cycles -> L,L,L,L,E repeating
    pat = 10'b01111_01111;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'd10, 1'b1, 32'h100 + i, 1'b1, 5'd11, 32'h200 + i, 2'd0, 2'd2, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
      chk("grant_seq", {31'd0, o_ldr}, {31'd0, pat[i]});
    end

    // Execute write to x0 is consumed but dropped
    cycle(1'b1, 5'd0, 1'b1, 32'hDEAD, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("x0_ex_ready", {31'd0, ex_ready}, 32'd1);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'h55, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("x0_no_write", {31'd0, o_wr}, 32'd0);
    chk("x0_no_bypass", o_rs1, 32'h55);

    // Bypass of pending r7 write
    cycle(1'b1, 5'd7, 1'b1, 32'hA5, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd7, 32'h11, 5'd7, 32'h22, o_wr, o_data, o_rs1, o_ldr);
    chk("bypass_r7", o_rs1, BYP ? 32'hA5 : 32'h11);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r1, r2;
      r1 = ($urandom_range(0, 1) == 0) ? pend_a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? pend_a : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), 1'($urandom), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
            2'($urandom), 2'($urandom), 1'($urandom),
            r1, $urandom, r2, $urandom, o_wr, o_data, o_rs1, o_ldr);
    end

    // Asynchronous reset while a write is pending
    cycle(1'b1, 5'd9, 1'b1, 32'h77, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    @(posedge clk); #1;
    ex_valid = 1'b1; ld_valid = 1'b1;
    #1;
    chk("pre_rst_wr_en", {31'd0, rd_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("async_rst_addr", {27'd0, rd_addr}, 32'd0);
    chk("async_rst_data", rd_data, 32'd0);
    chk("async_rst_readies", {30'd0, ex_ready, ld_ready}, 32'd0);
    exp_q.delete();
    starve = 0; pend_v = 1'b0; pend_a = 5'd0; pend_d = 32'd0;
    @(posedge clk); #3;
    chk("rst_hold_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("rst_hold_readies", {30'd0, ex_ready, ld_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0;
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);
    chk("post_rst_data", o_data, 32'd0);
    chk("post_rst_addr", {27'd0, rd_addr}, 32'd0);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, o_wr, o_data, o_rs1, o_ldr);

    @(negedge clk); #1;
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
